// File: rtl/gtx_mux_pkg.sv
// Shared types, header field layout and header builder for the GTX TX channel mux.
package gtx_mux_pkg;

    localparam logic [7:0] DEF_MAGIC     = 8'hA5;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_CONT_BIT  = 23;
    localparam int         HDR_ID_LSB    = 16;
    localparam int         HDR_SEQ_LSB   = 0;
    localparam int         SEQ_W         = 16;
    localparam int         ID_W          = 7;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } mux_state_e;

    function automatic logic [31:0] build_hdr(
        input logic [7:0]       magic,
        input logic             cont,
        input logic [ID_W-1:0]  id,
        input logic [SEQ_W-1:0] seq
    );
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 8]    = magic;
        hdr[HDR_CONT_BIT]          = cont;
        hdr[HDR_ID_LSB +: ID_W]    = id;
        hdr[HDR_SEQ_LSB +: SEQ_W]  = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/gtx_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr+1, modulo N_CH.
module gtx_rr_arb
    import gtx_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!gnt_vld && req[IDX_W'(idx)]) begin
                gnt_vld                = 1'b1;
                gnt_idx                = IDX_W'(idx);
                gnt_oh[IDX_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gtx_chan_mux.sv
// N-channel AXI4-Stream packet mux with header insertion and MAX_BEATS splitting.
//   state | meaning
//   IDLE  | arbitrate, latch header for the granted channel
//   HDR   | present header beat, wait for m_tready
//   DATA  | zero-latency passthrough of the granted channel
module gtx_chan_mux
    import gtx_mux_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         DATA_W    = 64,
    parameter int         MAX_BEATS = 256,
    parameter logic [7:0] MAGIC     = DEF_MAGIC
) (
    input  logic                     core_clk,
    input  logic                     aresetn,
    input  logic [N_CH*DATA_W-1:0]   s_tdata,
    input  logic [N_CH-1:0]          s_tvalid,
    input  logic [N_CH-1:0]          s_tlast,
    output logic [N_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    input  logic                     channel_up,
    output logic                     trunc_err,
    output logic                     busy
);

    localparam int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               CNT_W    = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    mux_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, rr_ptr_q, arb_idx, nxt_idx;
    logic [N_CH-1:0]   grant_oh_q, arb_oh;
    logic              arb_vld, cont_q, trunc_err_q;
    logic [SEQ_W-1:0]  seq_q [N_CH];
    logic [SEQ_W-1:0]  hdr_seq;
    logic [DATA_W-1:0] hdr_q;
    logic [CNT_W-1:0]  beats_left_q;
    logic [DATA_W-1:0] ch_data [N_CH];
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid, sel_last, at_max;
    logic              arb_take, hdr_acc, beat_acc, pkt_end, pkt_split;

    gtx_rr_arb #(.N_CH(N_CH)) u_arb (
        .req     (s_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_data[i] = s_tdata[i*DATA_W +: DATA_W];
        end
    end

    assign sel_data  = ch_data[grant_q];
    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign at_max    = (beats_left_q == '0);

    // A continuation keeps the channel and the seq of the header it continues.
    assign nxt_idx   = cont_q ? grant_q : arb_idx;
    assign hdr_seq   = cont_q ? hdr_q[HDR_SEQ_LSB +: SEQ_W] : seq_q[nxt_idx];

    assign trunc_err = trunc_err_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge core_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_tdata   = hdr_q;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        arb_take  = 1'b0;
        hdr_acc   = 1'b0;
        beat_acc  = 1'b0;
        pkt_end   = 1'b0;
        pkt_split = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (channel_up && (cont_q || arb_vld)) begin
                    arb_take = 1'b1;
                    state_d  = HDR;
                end
            end
            HDR: begin
                m_tvalid = 1'b1;
                if (m_tready) begin
                    hdr_acc = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_tdata  = sel_data;
                m_tvalid = sel_valid & channel_up;
                m_tlast  = sel_last | at_max;
                s_tready = grant_oh_q & {N_CH{m_tready & channel_up}};
                if (sel_valid && m_tready && channel_up) begin
                    beat_acc = 1'b1;
                    if (sel_last) begin
                        pkt_end = 1'b1;
                        state_d = IDLE;
                    end else if (at_max) begin
                        pkt_split = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q      <= '0;
            grant_oh_q   <= '0;
            rr_ptr_q     <= '0;
            cont_q       <= 1'b0;
            hdr_q        <= '0;
            beats_left_q <= '0;
            trunc_err_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            trunc_err_q <= pkt_split;
            if (arb_take) begin
                if (!cont_q) begin
                    grant_q    <= arb_idx;
                    grant_oh_q <= arb_oh;
                end
                hdr_q <= DATA_W'(build_hdr(MAGIC, cont_q, ID_W'(nxt_idx), hdr_seq));
            end
            if (hdr_acc) begin
                beats_left_q <= LAST_CNT;
                if (!cont_q) begin
                    seq_q[grant_q] <= seq_q[grant_q] + 16'd1;
                end
            end else if (beat_acc && !at_max) begin
                beats_left_q <= beats_left_q - 1'b1;
            end
            if (pkt_end) begin
                cont_q   <= 1'b0;
                rr_ptr_q <= grant_q;
            end
            if (pkt_split) begin
                cont_q <= 1'b1;
            end
        end
    end

endmodule
